dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the byte-addressable data memory
//  (negedge-write, combinational-read, size 000/001/010 = byte/half/word).

---
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer in front of the
// byte-addressable data memory. One access in flight; each request goes
// through IDLE -> ACCESS -> RESP. Illegal requests (bad size, misaligned,
// out of bounds) get resp_err and never touch the memory.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | arbitrate, assert req_ready to the winner, latch on handshake
//   ACCESS | drive memory from the latch, capture extended load data
//   RESP   | hold resp_valid/data/err for the owning port until consumed
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0][2:0]        req_size,
  output logic [1:0]             resp_valid,
  input  logic [1:0]             resp_ready,
  output logic [1:0][DATA_W-1:0] resp_rdata,
  output logic [1:0]             resp_err,
  output logic                   mem_wr_en,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [2:0]             mem_size,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              grant;
  logic              handshake;
  logic              illegal;
  logic [ADDR_W:0]   nbytes;
  logic [ADDR_W:0]   end_addr;
  logic [DATA_W-1:0] ext_data;

  // Round-robin pick: on contention the port that did not win last time goes.
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~last_grant_q : ~req_valid[0];
    handshake = (state_q == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (handshake) req_ready[grant] = 1'b1;
  end

  // Legality of the latched request; the bounds sum is one bit wider so it cannot wrap.
  always_comb begin
    case (size_q[1:0])
      2'b00:   nbytes = (ADDR_W+1)'(1);
      2'b01:   nbytes = (ADDR_W+1)'(2);
      default: nbytes = (ADDR_W+1)'(4);
    endcase
    end_addr = {1'b0, addr_q} + nbytes;
    illegal  = (size_q == 3'b011) || (size_q == 3'b110) || (size_q == 3'b111) ||
               (we_q && size_q[2]) ||
               ((size_q[1:0] == 2'b01) && addr_q[0]) ||
               ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) ||
               (end_addr > MEM_LIMIT);
  end

  // Sign/zero extension of the memory's low-aligned read data.
  always_comb begin
    case (size_q)
      3'b000:  ext_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ext_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010:  ext_data = mem_rdata;
      3'b100:  ext_data = {24'd0, mem_rdata[7:0]};
      3'b101:  ext_data = {16'd0, mem_rdata[15:0]};
      default: ext_data = '0;
    endcase
  end

  // Memory strobes; the write enable is gated by reset so no negedge write lands in a reset cycle.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_size  = {1'b0, size_q[1:0]};
    mem_wr_en = (state_q == ACCESS) && !illegal && we_q && !reset;
    mem_rd_en = (state_q == ACCESS) && !illegal && !we_q;
  end

  // Response outputs are only visible on the owning port while in RESP.
  always_comb begin
    resp_valid = 2'b00;
    resp_err   = 2'b00;
    resp_rdata = '0;
    if (state_q == RESP) begin
      resp_valid[port_q] = 1'b1;
      resp_err[port_q]   = err_q;
      resp_rdata[port_q] = rdata_q;
    end
  end

  // Next-state and latch updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          port_d       = grant;
          last_grant_d = grant;
          we_d         = req_we[grant];
          addr_d       = req_addr[grant];
          wdata_d      = req_wdata[grant];
          size_d       = req_size[grant];
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = illegal;
        rdata_d = (illegal || we_q) ? '0 : ext_data;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready[port_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, synchronously reset; port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= 3'b000;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-byte memory
// (negedge write, combinational low-aligned read).
module tb_dmem_arbiter;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][2:0]  req_size;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [1:0][31:0] resp_rdata;
  logic [1:0]       resp_err;
  logic             mem_wr_en;
  logic             mem_rd_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [2:0]       mem_size;
  logic [31:0]      mem_rdata;

  int vecs = 0;
  int errs = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    case (mem_size[1:0])
      2'b00:   mem_rdata = {24'd0, mem[a0]};
      2'b01:   mem_rdata = {16'd0, mem[a1], mem[a0]};
      default: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(negedge clk) begin
    if (mem_wr_en) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_size[1:0] != 2'b00) mem[a1] <= mem_wdata[15:8];
      if (mem_size[1:0] == 2'b10) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs one request on port p to completion; results are checked by the caller.
  task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic mem_seen, output logic to);
    int n;
    to = 1'b0; mem_seen = 1'b0; lat = 0; rdata = 32'hx; err = 1'bx;
    @(negedge clk);
    req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = addr;
    req_wdata[p] = wdata; req_size[p] = size;
    n = 0;
    #1;
    while (!req_ready[p] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      req_valid[p] = 1'b0; to = 1'b1; return;
    end
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_wr_en || mem_rd_en) mem_seen = 1'b1;
      if (resp_valid[p]) break;
    end
    if (!resp_valid[p]) begin
      to = 1'b1; return;
    end
    rdata = resp_rdata[p];
    err   = resp_err[p];
    resp_ready[p] = 1'b1;
    @(posedge clk);
    #1 resp_ready[p] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (mem_wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
    #1 reset = 1'b0;
    @(negedge clk);
    vecs++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    vecs++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    vecs++; if (resp_err !== 2'b00) begin errs++; $display("FAIL reset_resp_err got %b want 00", resp_err); end
    vecs++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin errs++; $display("FAIL reset_mem_en got %b want 00", {mem_wr_en, mem_rd_en}); end
    vecs++; if (resp_rdata !== 64'd0) begin errs++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er, ms, to; int lat;
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat, ms, to);
    vecs++; if (to !== 1'b0 || er !== 1'b0 || lat != 2 || ms !== 1'b1) begin errs++; $display("FAIL sw_0x10 to=%b err=%b lat=%0d mem=%b want 0 0 2 1", to, er, lat, ms); end
    do_txn(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, ms, to);
    vecs++; if (to !== 1'b0 || rd !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_0x10 got %h to=%b want deadbeef", rd, to); end
    vecs++; if (er !== 1'b0 || lat != 2) begin errs++; $display("FAIL lw_0x10_err_lat err=%b lat=%0d want 0 2", er, lat); end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er, ms, to; int lat;
    do_txn(0, 1'b1, 32'h20, 32'h00000080, 3'b000, rd, er, lat, ms, to);
    vecs++; if (to !== 1'b0 || er !== 1'b0) begin errs++; $display("FAIL sb_0x20 to=%b err=%b want 0 0", to, er); end
    do_txn(1, 1'b0, 32'h20, 32'h0, 3'b000, rd, er, lat, ms, to);
    vecs++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errs++; $display("FAIL lb_0x20 got %h err=%b want ffffff80", rd, er); end
    do_txn(0, 1'b0, 32'h20, 32'h0, 3'b100, rd, er, lat, ms, to);
    vecs++; if (rd !== 32'h00000080 || er !== 1'b0) begin errs++; $display("FAIL lbu_0x20 got %h err=%b want 00000080", rd, er); end
    do_txn(0, 1'b1, 32'h22, 32'hABCD8001, 3'b001, rd, er, lat, ms, to);
    vecs++; if (to !== 1'b0 || er !== 1'b0) begin errs++; $display("FAIL sh_0x22 to=%b err=%b want 0 0", to, er); end
    do_txn(0, 1'b0, 32'h22, 32'h0, 3'b001, rd, er, lat, ms, to);
    vecs++; if (rd !== 32'hFFFF8001) begin errs++; $display("FAIL lh_0x22 got %h want ffff8001", rd); end
    do_txn(1, 1'b0, 32'h22, 32'h0, 3'b101, rd, er, lat, ms, to);
    vecs++; if (rd !== 32'h00008001) begin errs++; $display("FAIL lhu_0x22 got %h want 00008001", rd); end
    do_txn(1, 1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, ms, to);
    vecs++; if (rd !== 32'h80010080) begin errs++; $display("FAIL lw_0x20 got %h want 80010080", rd); end
  endtask

  task automatic test_round_robin();
    int exp_g [4] = '{0, 1, 0, 1};
    int g [4];
    int ng, n;
    logic saw0, saw_resp;
    reset = 1'b1;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_size[0] = 3'b010; req_size[1] = 3'b010;
    resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ng = 0; n = 0;
    while (ng < 4 && n < 40) begin
      @(negedge clk); n++;
      if (req_ready != 2'b00) begin
        g[ng] = req_ready[1] ? 1 : 0;
        if (req_ready == 2'b11) g[ng] = 9;
        ng++;
      end
    end
    req_valid = 2'b10;
    vecs++; if (ng != 4) begin errs++; $display("FAIL rr_grant_count got %0d want 4", ng); end
    for (int i = 0; i < ng; i++) begin
      vecs++; if (g[i] != exp_g[i]) begin errs++; $display("FAIL rr_grant_%0d got %0d want %0d", i, g[i], exp_g[i]); end
    end
    ng = 0; n = 0; saw0 = 1'b0;
    while (ng < 3 && n < 40) begin
      @(negedge clk); n++;
      if (req_ready[0]) saw0 = 1'b1;
      if (req_ready[1]) ng++;
    end
    req_valid = 2'b00;
    vecs++; if (ng != 3 || saw0 !== 1'b0) begin errs++; $display("FAIL p1_alone grants=%0d saw_p0=%b want 3 0", ng, saw0); end
    saw_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid != 2'b00) saw_resp = 1'b1;
    end
    vecs++; if (saw_resp !== 1'b0) begin errs++; $display("FAIL withdraw_granted got resp=%b want 0", saw_resp); end
    resp_ready = 2'b00;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, ms, to; int lat;
    logic [31:0] ea [5] = '{32'h13, 32'h11, 32'hFE, 32'h0, 32'h40};
    logic [2:0]  es [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic        ew [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_txn(i % 2, ew[i], ea[i], 32'hFFFFFFFF, es[i], rd, er, lat, ms, to);
      vecs++; if (to !== 1'b0 || er !== 1'b1 || rd !== 32'd0 || ms !== 1'b0) begin
        errs++; $display("FAIL err_case_%0d to=%b err=%b rdata=%h mem=%b want 0 1 0 0", i, to, er, rd, ms);
      end
    end
    do_txn(0, 1'b0, 32'hFC, 32'h0, 3'b010, rd, er, lat, ms, to);
    vecs++; if (er !== 1'b0 || ms !== 1'b1 || rd !== 32'd0) begin errs++; $display("FAIL lw_0xfc err=%b mem=%b rdata=%h want 0 1 0", er, ms, rd); end
    do_txn(1, 1'b0, 32'hFF, 32'h0, 3'b100, rd, er, lat, ms, to);
    vecs++; if (er !== 1'b0 || ms !== 1'b1) begin errs++; $display("FAIL lbu_0xff err=%b mem=%b want 0 1", er, ms); end
    do_txn(0, 1'b0, 32'hFE, 32'h0, 3'b001, rd, er, lat, ms, to);
    vecs++; if (er !== 1'b0) begin errs++; $display("FAIL lh_0xfe err=%b want 0", er); end
  endtask

  task automatic test_hold_resp();
    logic ok;
    do_reset();
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00;
    req_addr[0] = 32'h10; req_size[0] = 3'b010;
    req_addr[1] = 32'h20; req_size[1] = 3'b010;
    resp_ready = 2'b00;
    #1;
    vecs++; if (req_ready !== 2'b01) begin errs++; $display("FAIL hold_first_grant got %b want 01", req_ready); end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 2'b01 || resp_rdata[0] !== 32'hDEADBEEF || resp_err !== 2'b00 || req_ready[1] !== 1'b0) ok = 1'b0;
    end
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL hold_stable last resp_valid=%b rdata=%h req_ready=%b want 01 deadbeef 00", resp_valid, resp_rdata[0], req_ready); end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1 resp_ready[0] = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    vecs++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL hold_release got %b want 00", resp_valid); end
  endtask

  task automatic test_reset_access();
    logic [31:0] rd; logic er, ms, to; int lat;
    logic rv;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'h00000055; req_size[0] = 3'b010;
    #1;
    vecs++; if (req_ready[0] !== 1'b1) begin errs++; $display("FAIL rst_acc_ready got %b want 1", req_ready[0]); end
    @(posedge clk);
    #1 req_valid[0] = 1'b0; reset = 1'b1;
    @(negedge clk);
    vecs++; if (mem_wr_en !== 1'b0) begin errs++; $display("FAIL rst_acc_wr_en got %b want 0", mem_wr_en); end
    @(posedge clk);
    #1;
    vecs++; if ({req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en} !== 8'd0 || resp_rdata !== 64'd0) begin
      errs++; $display("FAIL rst_acc_outputs got rdy=%b rv=%b err=%b wr=%b rd=%b want all 0", req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en);
    end
    reset = 1'b0;
    rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || mem_wr_en) rv = 1'b1;
    end
    vecs++; if (rv !== 1'b0) begin errs++; $display("FAIL rst_acc_dropped got activity=%b want 0", rv); end
    do_txn(0, 1'b0, 32'h30, 32'h0, 3'b010, rd, er, lat, ms, to);
    vecs++; if (to !== 1'b0 || rd !== 32'd0 || er !== 1'b0) begin errs++; $display("FAIL rst_acc_lw_0x30 got %h err=%b want 0", rd, er); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    req_size = '0; resp_ready = 2'b00;
    test_reset();
    test_word();
    test_extend();
    test_round_robin();
    test_errors();
    test_hold_resp();
    test_reset_access();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
